// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Instruction-memory request/grant/response bus between the fetch unit and
// instruction memory.
//   oImemReq    fetch -> mem  read request valid
//   oImemAddr   fetch -> mem  word-aligned read address, held until granted
//   iImemGnt    mem -> fetch  request accepted this cycle
//   iImemRvalid mem -> fetch  response valid, responses return in request order
//   iImemRdata  mem -> fetch  response instruction word
// -----------------------------------------------------------------------------
interface inst_fetch_if #(
    parameter int cXLEN = 32
);
    logic             oImemReq;
    logic [cXLEN-1:0] oImemAddr;
    logic             iImemGnt;
    logic             iImemRvalid;
    logic [cXLEN-1:0] iImemRdata;

    modport master (
        output oImemReq,
        output oImemAddr,
        input  iImemGnt,
        input  iImemRvalid,
        input  iImemRdata
    );

    modport slave (
        input  oImemReq,
        input  oImemAddr,
        output iImemGnt,
        output iImemRvalid,
        output iImemRdata
    );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit. Owns the program counter, issues in-order reads to
// instruction memory, buffers returned words with their PC in a small FIFO and
// hands them to the decoder one per cycle. A branch/jump redirect flushes the
// FIFO and discards every response still owed for the wrong path.
//
// Ports
//   iClk, iRst     clock, synchronous active-high reset
//   imem           instruction-memory bus (master side)
//   iStall         decoder cannot take a new instruction; outputs hold
//   iBranchTaken   redirect request from execute
//   iBranchPc      redirect target
//   oInst          instruction to decoder (NOP when nothing valid)
//   oCurPc         PC of oInst
//   oInstDv        oInst/oCurPc valid
//   oMisalign      one-cycle pulse: redirect target was not word aligned
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] cResetPc   = 32'h0000_0000,
    parameter int          cFifoDepth = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    inst_fetch_if.master        imem,
    input  logic                iStall,
    input  logic                iBranchTaken,
    input  logic [31:0]         iBranchPc,
    output logic [31:0]         oInst,
    output logic [31:0]         oCurPc,
    output logic                oInstDv,
    output logic                oMisalign
);
    localparam int               cCntW     = $clog2(cFifoDepth + 1);
    localparam int               cPtrW     = (cFifoDepth > 1) ? $clog2(cFifoDepth) : 1;
    localparam logic [cCntW-1:0] cDepthCnt = cCntW'(cFifoDepth);
    localparam logic [31:0]      cNop      = 32'h0000_0013;

    typedef enum logic [1:0] {
        sReset = 2'd0,
        sFetch = 2'd1,
        sDrain = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        push_pc_q, push_pc_d;
    logic [cCntW-1:0]   outstanding_q, outstanding_d;
    logic [cCntW-1:0]   discard_cnt_q, discard_cnt_d;
    logic [cCntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [cPtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [cPtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        cur_pc_q, cur_pc_d;
    logic               inst_dv_q, inst_dv_d;
    logic               misalign_q, misalign_d;

    logic [31:0]        fifo_inst_q [cFifoDepth];
    logic [31:0]        fifo_pc_q   [cFifoDepth];

    logic               req;
    logic               gnt_fire;
    logic               rsp;
    logic               push;
    logic               pop;
    logic               redirect;
    logic [cCntW:0]     inflight;

    // Requests are throttled so every outstanding response is guaranteed a
    // FIFO slot: outstanding + buffered never exceeds the FIFO depth.
    assign inflight = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    assign req      = (state_q == sFetch) && (inflight < {1'b0, cDepthCnt});
    assign gnt_fire = req && imem.iImemGnt;
    assign rsp      = imem.iImemRvalid;
    assign redirect = iBranchTaken;
    assign push     = rsp && (discard_cnt_q == '0) && !redirect;
    assign pop      = !redirect && !iStall && (fifo_cnt_q != '0);

    assign imem.oImemReq  = req;
    assign imem.oImemAddr = fetch_pc_q;
    assign oInst          = inst_q;
    assign oCurPc         = cur_pc_q;
    assign oInstDv        = inst_dv_q;
    assign oMisalign      = misalign_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        push_pc_d     = push_pc_q;
        outstanding_d = outstanding_q + cCntW'(gnt_fire) - cCntW'(rsp);
        discard_cnt_d = discard_cnt_q;
        fifo_cnt_d    = fifo_cnt_q + cCntW'(push) - cCntW'(pop);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        inst_d        = inst_q;
        cur_pc_d      = cur_pc_q;
        inst_dv_d     = inst_dv_q;
        misalign_d    = 1'b0;

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            push_pc_d = push_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + cPtrW'(1);
        end
        if (rsp && (discard_cnt_q != '0)) begin
            discard_cnt_d = discard_cnt_q - cCntW'(1);
        end

        // Decoder output register
        if (pop) begin
            inst_d    = fifo_inst_q[rd_ptr_q];
            cur_pc_d  = fifo_pc_q[rd_ptr_q];
            inst_dv_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + cPtrW'(1);
        end else if (!iStall) begin
            inst_d    = cNop;
            inst_dv_d = 1'b0;
        end

        case (state_q)
            sReset:  state_d = sFetch;
            sFetch:  state_d = sFetch;
            sDrain:  if (discard_cnt_d == '0) state_d = sFetch;
            default: state_d = sReset;
        endcase

        // Redirect overrides everything above. Every transaction still owed by
        // memory after this cycle (which is exactly outstanding_d) belongs to
        // the wrong path; in sDrain this equals the running discard count, so
        // the same load also "keeps" the count there.
        if (redirect) begin
            fetch_pc_d    = {iBranchPc[31:2], 2'b00};
            push_pc_d     = {iBranchPc[31:2], 2'b00};
            discard_cnt_d = outstanding_d;
            fifo_cnt_d    = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            inst_d        = cNop;
            inst_dv_d     = 1'b0;
            misalign_d    = (iBranchPc[1:0] != 2'b00);
            state_d       = (outstanding_d != '0) ? sDrain : sFetch;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q       <= sReset;
            fetch_pc_q    <= cResetPc;
            push_pc_q     <= cResetPc;
            outstanding_q <= '0;
            discard_cnt_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inst_q        <= cNop;
            cur_pc_q      <= '0;
            inst_dv_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            push_pc_q     <= push_pc_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inst_q        <= inst_d;
            cur_pc_q      <= cur_pc_d;
            inst_dv_q     <= inst_dv_d;
            misalign_q    <= misalign_d;
        end
    end

    // FIFO storage carries only data, so it needs no reset.
    always_ff @(posedge iClk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem.iImemRdata;
            fifo_pc_q[wr_ptr_q]   <= push_pc_q;
        end
    end

    // Counter overflow/underflow means memory broke the protocol or the
    // throttle is wrong.
    always @(posedge iClk) begin
        if (!iRst) begin
            assert (!(rsp && (outstanding_q == '0)));
            assert (!(gnt_fire && !rsp && (outstanding_q == cDepthCnt)));
            assert (!(push && !pop && (fifo_cnt_q == cDepthCnt)));
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStall;
    logic        iBranchTaken;
    logic [31:0] iBranchPc;
    logic [31:0] oInst;
    logic [31:0] oCurPc;
    logic        oInstDv;
    logic        oMisalign;

    inst_fetch_if imem ();

    inst_fetch #(
        .cResetPc   (RESET_PC),
        .cFifoDepth (DEPTH)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .imem         (imem),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iBranchPc    (iBranchPc),
        .oInst        (oInst),
        .oCurPc       (oCurPc),
        .oInstDv      (oInstDv),
        .oMisalign    (oMisalign)
    );

    always #5 iClk = ~iClk;

    // Memory transactions granted but not yet answered, in request order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        int          due;
        bit          stale;
    } mreq_t;

    // Instructions that have come back on the right path and await the decoder.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } dlv_t;

    mreq_t       memq[$];
    dlv_t        expq[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] word_key = 32'h0;
    logic [31:0] exp_fetch;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_dv;
    bit          in_sreset;
    bit          want_first;
    logic [31:0] first_pc;
    logic [31:0] prev_obs_pc;
    bit          seen_wrap;
    int          dlv_cnt = 0;
    int          mis_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit has_stale();
        foreach (memq[i]) if (memq[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        iRst = 1'b1;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        iBranchPc = 32'h0;
        imem.iImemGnt = 1'b0;
        imem.iImemRvalid = 1'b0;
        imem.iImemRdata = 32'h0;
        repeat (3) begin
            @(posedge iClk);
            #1;
            cyc++;
        end
        chk("rst_req", 64'(imem.oImemReq), 64'(0));
        chk("rst_addr", 64'(imem.oImemAddr), 64'(RESET_PC));
        chk("rst_inst", 64'(oInst), 64'(NOP));
        chk("rst_pc", 64'(oCurPc), 64'(0));
        chk("rst_dv", 64'(oInstDv), 64'(0));
        chk("rst_misalign", 64'(oMisalign), 64'(0));
        memq.delete();
        expq.delete();
        exp_fetch = RESET_PC;
        m_inst = NOP;
        m_pc = 32'h0;
        m_dv = 1'b0;
        in_sreset = 1'b1;
        want_first = 1'b0;
        iRst = 1'b0;
    endtask

    // One clock: drive inputs, check the request side before the edge, then
    // check the decoder side after it and advance the reference model.
    task automatic step(input bit st, input bit br, input logic [31:0] bpc, input bit g);
        bit    rv;
        bit    req_s;
        bit    gfire;
        bit    exp_req;
        int    pre_n;
        mreq_t h;
        mreq_t nr;
        dlv_t  e;

        rv = (memq.size() > 0) && (memq[0].due <= cyc + 1);
        iStall = st;
        iBranchTaken = br;
        iBranchPc = bpc;
        imem.iImemGnt = g;
        imem.iImemRvalid = rv;
        if (rv) imem.iImemRdata = memq[0].word;
        else    imem.iImemRdata = $urandom;

        req_s = imem.oImemReq;
        exp_req = !in_sreset && !has_stale() && ((memq.size() + expq.size()) < DEPTH);
        chk("req", 64'(req_s), 64'(exp_req));
        if (req_s) chk("addr", 64'(imem.oImemAddr), 64'(exp_fetch));
        gfire = req_s && g;
        pre_n = expq.size();

        @(posedge iClk);
        #1;
        cyc++;

        if (br) begin
            m_inst = NOP;
            m_dv = 1'b0;
        end else if (!st) begin
            if (pre_n > 0) begin
                e = expq.pop_front();
                m_pc = e.pc;
                m_inst = e.word;
                m_dv = 1'b1;
            end else begin
                m_inst = NOP;
                m_dv = 1'b0;
            end
        end
        chk("out_pc_inst", {oCurPc, oInst}, {m_pc, m_inst});
        chk("out_dv", 64'(oInstDv), 64'(m_dv));
        chk("misalign", 64'(oMisalign), 64'(br && (bpc[1:0] != 2'b00)));

        if (oMisalign) mis_cnt++;
        if (!br && !st && oInstDv) begin
            dlv_cnt++;
            if (want_first) begin
                first_pc = oCurPc;
                want_first = 1'b0;
            end
            if (prev_obs_pc == 32'hFFFF_FFFC && oCurPc == 32'h0) seen_wrap = 1'b1;
            prev_obs_pc = oCurPc;
        end

        if (rv) begin
            h = memq.pop_front();
            if (!h.stale && !br) begin
                e.pc = h.pc;
                e.word = h.word;
                expq.push_back(e);
            end
        end
        if (gfire) begin
            nr.pc = exp_fetch;
            nr.word = exp_fetch ^ word_key;
            nr.due = cyc + int'($urandom_range(lat_max, lat_min));
            nr.stale = 1'b0;
            memq.push_back(nr);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (br) begin
            expq.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            exp_fetch = {bpc[31:2], 2'b00};
            want_first = 1'b1;
        end
        in_sreset = 1'b0;
    endtask

    initial begin
        int          d0;
        int          m0;
        logic [31:0] a0;
        bit          st;
        bit          br;
        bit          g;

        prev_obs_pc = 32'h0;
        seen_wrap = 1'b0;
        first_pc = 32'h0;

        // Sequential fetch from reset, 1-cycle memory, rdata = addr
        do_reset();
        lat_min = 1;
        lat_max = 1;
        word_key = 32'h0;
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
        d0 = dlv_cnt;
        repeat (16) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("throughput", 64'(dlv_cnt - d0), 64'(16));

        // PC wraps past 0xFFFF_FFFC
        step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_seen", 64'(seen_wrap), 64'(1));

        // Long stall fills the pipe, then release
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("stall_req_low", 64'(imem.oImemReq), 64'(0));
        d0 = dlv_cnt;
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stall_release_dlv", 64'(dlv_cnt - d0), 64'(10));

        // Latency-3 memory, two requests owed, redirect to 0x100
        do_reset();
        lat_min = 3;
        lat_max = 3;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_first_pc", 64'(first_pc), 64'(32'h100));

        // Misaligned redirect target
        lat_min = 1;
        lat_max = 1;
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
        m0 = mis_cnt;
        step(1'b0, 1'b1, 32'h103, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("misalign_once", 64'(mis_cnt - m0), 64'(1));
        chk("misalign_first_pc", 64'(first_pc), 64'(32'h100));

        // Redirect coinciding with grant and rvalid
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("coincide_req", 64'(imem.oImemReq), 64'(1));
        step(1'b0, 1'b1, 32'h200, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("coincide_first_pc", 64'(first_pc), 64'(32'h200));

        // Grant withheld for 5 cycles
        a0 = exp_fetch;
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("gnt_low_addr", 64'(imem.oImemAddr), 64'(a0));
        chk("gnt_low_req", 64'(imem.oImemReq), 64'(1));
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic with a reset in the middle
        word_key = 32'hC0DE_5A5A;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            st = ($urandom_range(99, 0) < 30);
            g  = ($urandom_range(99, 0) < 75);
            br = ($urandom_range(99, 0) < 3) && !in_sreset;
            step(st, br, $urandom, g);
        end
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
